// File: rtl/scmp_status_reg.sv
// SC/MP status register: ALU flag capture, CAS writes, the interrupt-enable bit,
// the F2..F0 user flags and the sense-pin synchronisers feeding interrupt qualification.
module scmp_status_reg #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       alu_cy_i,
    input  logic       alu_ov_i,
    input  logic       alu_hcy_i,
    input  logic       ld_cy_i,
    input  logic       ld_ov_i,
    input  logic       ld_hcy_i,
    input  logic       sr_wr_i,
    input  logic [7:0] sr_d_i,
    input  logic       ien_i,
    input  logic       dint_i,
    input  logic       int_ack_i,
    input  logic       sense_a_i,
    input  logic       sense_b_i,
    output logic [7:0] sr_o,
    output logic       cy_o,
    output logic       ov_o,
    output logic       hcy_o,
    output logic [2:0] flag_o,
    output logic       int_req_o
);

    logic                   r_cy;
    logic                   r_ov;
    logic                   r_hcy;
    logic                   r_ie;
    logic [2:0]             r_f;
    logic [SYNC_STAGES-1:0] r_sa_sync;
    logic [SYNC_STAGES-1:0] r_sb_sync;

    logic                   w_cy_nxt;
    logic                   w_ov_nxt;
    logic                   w_hcy_nxt;
    logic                   w_ie_nxt;
    logic [2:0]             w_f_nxt;
    logic                   w_sa_last;
    logic                   w_sb_last;

    // Next-state selection; a CAS write overrides ALU captures, an acknowledge overrides everything on IE.
    always_comb begin
        w_cy_nxt  = r_cy;
        w_ov_nxt  = r_ov;
        w_hcy_nxt = r_hcy;
        w_ie_nxt  = r_ie;
        w_f_nxt   = r_f;
        if (sr_wr_i) begin
            w_cy_nxt = sr_d_i[7];
            w_ov_nxt = sr_d_i[6];
            w_f_nxt  = sr_d_i[2:0];
        end else begin
            if (ld_cy_i) begin
                w_cy_nxt = alu_cy_i;
            end else begin
                w_cy_nxt = r_cy;
            end
            if (ld_ov_i) begin
                w_ov_nxt = alu_ov_i;
            end else begin
                w_ov_nxt = r_ov;
            end
        end
        if (ld_hcy_i) begin
            w_hcy_nxt = alu_hcy_i;
        end else begin
            w_hcy_nxt = r_hcy;
        end
        if (int_ack_i) begin
            w_ie_nxt = 1'b0;
        end else if (sr_wr_i) begin
            w_ie_nxt = sr_d_i[3];
        end else if (dint_i) begin
            w_ie_nxt = 1'b0;
        end else if (ien_i) begin
            w_ie_nxt = 1'b1;
        end else begin
            w_ie_nxt = r_ie;
        end
    end

    // Architectural state and sense synchronisers; synchronisers shift regardless of strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cy      <= 1'b0;
            r_ov      <= 1'b0;
            r_hcy     <= 1'b0;
            r_ie      <= 1'b0;
            r_f       <= 3'b000;
            r_sa_sync <= {SYNC_STAGES{1'b0}};
            r_sb_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_cy      <= w_cy_nxt;
            r_ov      <= w_ov_nxt;
            r_hcy     <= w_hcy_nxt;
            r_ie      <= w_ie_nxt;
            r_f       <= w_f_nxt;
            r_sa_sync <= {r_sa_sync[SYNC_STAGES-2:0], sense_a_i};
            r_sb_sync <= {r_sb_sync[SYNC_STAGES-2:0], sense_b_i};
        end
    end

    assign w_sa_last = r_sa_sync[SYNC_STAGES-1];
    assign w_sb_last = r_sb_sync[SYNC_STAGES-1];

    assign sr_o      = {r_cy, r_ov, w_sb_last, w_sa_last, r_ie, r_f};
    assign cy_o      = r_cy;
    assign ov_o      = r_ov;
    assign hcy_o     = r_hcy;
    assign flag_o    = r_f;
    assign int_req_o = r_ie & w_sa_last;

endmodule

// File: tb/tb_scmp_status_reg.sv
// Randomised and directed bench for scmp_status_reg (depth-2 and depth-3 instances).
module tb_scmp_status_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, alu_cy = 1'b0, alu_ov = 1'b0, alu_hcy = 1'b0;
    logic       ld_cy = 1'b0, ld_ov = 1'b0, ld_hcy = 1'b0, sr_wr = 1'b0;
    logic [7:0] sr_d = 8'h00;
    logic       ien = 1'b0, dint = 1'b0, int_ack = 1'b0, sense_a = 1'b0, sense_b = 1'b0;

    logic [7:0] sr2, sr3;
    logic       cy2, ov2, hcy2, irq2, cy3, ov3, hcy3, irq3;
    logic [2:0] fl2, fl3;

    scmp_status_reg #(.SYNC_STAGES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .alu_cy_i(alu_cy), .alu_ov_i(alu_ov), .alu_hcy_i(alu_hcy),
        .ld_cy_i(ld_cy), .ld_ov_i(ld_ov), .ld_hcy_i(ld_hcy), .sr_wr_i(sr_wr), .sr_d_i(sr_d),
        .ien_i(ien), .dint_i(dint), .int_ack_i(int_ack), .sense_a_i(sense_a), .sense_b_i(sense_b),
        .sr_o(sr2), .cy_o(cy2), .ov_o(ov2), .hcy_o(hcy2), .flag_o(fl2), .int_req_o(irq2));

    scmp_status_reg #(.SYNC_STAGES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .alu_cy_i(alu_cy), .alu_ov_i(alu_ov), .alu_hcy_i(alu_hcy),
        .ld_cy_i(ld_cy), .ld_ov_i(ld_ov), .ld_hcy_i(ld_hcy), .sr_wr_i(sr_wr), .sr_d_i(sr_d),
        .ien_i(ien), .dint_i(dint), .int_ack_i(int_ack), .sense_a_i(sense_a), .sense_b_i(sense_b),
        .sr_o(sr3), .cy_o(cy3), .ov_o(ov3), .hcy_o(hcy3), .flag_o(fl3), .int_req_o(irq3));

    int passed = 0;
    int total  = 0;

    // Reference model: architectural bits plus pin-sample histories since the last reset.
    bit       m_cy, m_ov, m_hcy, m_ie;
    bit [2:0] m_f;
    bit       hist_a[$];
    bit       hist_b[$];

    // A sense level sampled at edge k is visible after edge k+s-1, i.e. s samples back.
    function automatic bit seen(input bit h[$], input int s);
        if (h.size() >= s) return h[h.size() - s];
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_sr(input int s);
        return {m_cy, m_ov, seen(hist_b, s), seen(hist_a, s), m_ie, m_f};
    endfunction

    function automatic logic exp_irq(input int s);
        return m_ie & seen(hist_a, s);
    endfunction

    task automatic tick();
        if (rst) begin
            m_cy = 1'b0; m_ov = 1'b0; m_hcy = 1'b0; m_ie = 1'b0; m_f = 3'b000;
            hist_a.delete();
            hist_b.delete();
        end else begin
            if (int_ack)    m_ie = 1'b0;
            else if (sr_wr) m_ie = sr_d[3];
            else if (dint)  m_ie = 1'b0;
            else if (ien)   m_ie = 1'b1;
            if (sr_wr) begin
                m_cy = sr_d[7]; m_ov = sr_d[6]; m_f = sr_d[2:0];
            end else begin
                if (ld_cy) m_cy = alu_cy;
                if (ld_ov) m_ov = alu_ov;
            end
            if (ld_hcy) m_hcy = alu_hcy;
            hist_a.push_back(sense_a);
            hist_b.push_back(sense_b);
            if (hist_a.size() > 4) void'(hist_a.pop_front());
            if (hist_b.size() > 4) void'(hist_b.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 1'b0; ld_cy = 1'b0; ld_ov = 1'b0; ld_hcy = 1'b0; sr_wr = 1'b0;
        ien = 1'b0; dint = 1'b0; int_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sense_a = 1'b1; sr_d = 8'hFF; sr_wr = 1'b1;
        ld_cy = 1'b1; ld_ov = 1'b1; ld_hcy = 1'b1; alu_cy = 1'b1; alu_ov = 1'b1; alu_hcy = 1'b1;
        ien = 1'b1;
        tick();
        total++; if (sr2 !== 8'h00) $display("FAIL reset_sr: got %h want 00", sr2); else passed++;
        total++; if ({cy2, ov2, hcy2, fl2, irq2} !== 7'b0) $display("FAIL reset_outs: got %b want 0", {cy2, ov2, hcy2, fl2, irq2}); else passed++;
        clr();
        tick();
        total++; if (sr2[4] !== 1'b0) $display("FAIL reset_sa_edge1: got %b want 0", sr2[4]); else passed++;
        tick();
        total++; if (sr2[4] !== 1'b1) $display("FAIL reset_sa_edge2: got %b want 1", sr2[4]); else passed++;
        sense_a = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_flag_capture();
        alu_cy = 1'b1; alu_ov = 1'b1; alu_hcy = 1'b1; ld_cy = 1'b1;
        tick();
        total++; if ({cy2, ov2, hcy2} !== 3'b100) $display("FAIL cap_cy_only: got %b want 100", {cy2, ov2, hcy2}); else passed++;
        ld_cy = 1'b0; ld_ov = 1'b1; ld_hcy = 1'b1;
        tick();
        total++; if ({cy2, ov2, hcy2} !== 3'b111) $display("FAIL cap_ov_hcy: got %b want 111", {cy2, ov2, hcy2}); else passed++;
        clr();
    endtask

    task automatic test_cas_conflict();
        sense_a = 1'b0; sense_b = 1'b0;
        sr_wr = 1'b1; sr_d = 8'h3A; ld_cy = 1'b1; alu_cy = 1'b1;
        tick();
        total++; if (sr2 !== 8'h0A) $display("FAIL cas_sr: got %h want 0a", sr2); else passed++;
        total++; if (fl2 !== 3'b010) $display("FAIL cas_flag: got %b want 010", fl2); else passed++;
        total++; if (hcy2 !== 1'b1) $display("FAIL cas_hcy_kept: got %b want 1", hcy2); else passed++;
        clr();
    endtask

    task automatic test_ie_priority();
        ien = 1'b1; dint = 1'b1;
        tick();
        total++; if (sr2[3] !== 1'b0) $display("FAIL ie_dint_wins: got %b want 0", sr2[3]); else passed++;
        clr(); ien = 1'b1;
        tick();
        total++; if (sr2[3] !== 1'b1) $display("FAIL ie_set: got %b want 1", sr2[3]); else passed++;
        ien = 1'b1; sr_wr = 1'b1; sr_d = 8'h00;
        tick();
        total++; if (sr2[3] !== 1'b0) $display("FAIL ie_srwr_wins: got %b want 0", sr2[3]); else passed++;
        clr(); ien = 1'b1;
        tick();
        ien = 1'b1; int_ack = 1'b1; sr_wr = 1'b1; sr_d = 8'h08;
        tick();
        total++; if (sr2[3] !== 1'b0) $display("FAIL ie_ack_wins: got %b want 0", sr2[3]); else passed++;
        clr();
    endtask

    task automatic test_interrupt();
        sense_a = 1'b1;
        tick(); tick();
        total++; if (irq2 !== 1'b0) $display("FAIL irq_no_ie: got %b want 0", irq2); else passed++;
        ien = 1'b1;
        tick();
        total++; if (irq2 !== 1'b1) $display("FAIL irq_raise: got %b want 1", irq2); else passed++;
        clr(); int_ack = 1'b1;
        tick();
        total++; if (irq2 !== 1'b0) $display("FAIL irq_ack: got %b want 0", irq2); else passed++;
        clr(); ien = 1'b1;
        tick();
        clr(); sense_a = 1'b0;
        tick();
        total++; if (irq2 !== 1'b1) $display("FAIL irq_hold1: got %b want 1", irq2); else passed++;
        tick();
        total++; if (irq2 !== 1'b0) $display("FAIL irq_sa_drop: got %b want 0", irq2); else passed++;
    endtask

    task automatic test_sync_depth();
        logic lvl;
        repeat (3) tick();
        for (int t = 0; t < 2; t++) begin
            lvl = (t == 0) ? 1'b1 : 1'b0;
            sense_b = lvl;
            for (int e = 1; e <= 3; e++) begin
                tick();
                total++;
                if (sr3 !== exp_sr(3) || sr3[5] !== ((e == 3) ? lvl : ~lvl))
                    $display("FAIL sync3_edge%0d: got %h want %h", e, sr3, exp_sr(3));
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            ld_cy = ($urandom_range(0, 2) == 0); ld_ov = ($urandom_range(0, 2) == 0);
            ld_hcy = ($urandom_range(0, 2) == 0); sr_wr = ($urandom_range(0, 5) == 0);
            ien = ($urandom_range(0, 3) == 0); dint = ($urandom_range(0, 4) == 0);
            int_ack = ($urandom_range(0, 6) == 0);
            alu_cy = $urandom_range(0, 1); alu_ov = $urandom_range(0, 1); alu_hcy = $urandom_range(0, 1);
            sr_d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) sense_a = ~sense_a;
            if ($urandom_range(0, 3) == 0) sense_b = ~sense_b;
            tick();
            total++; if (sr2 !== exp_sr(2)) $display("FAIL rnd_sr2 @%0d: got %h want %h", n, sr2, exp_sr(2)); else passed++;
            total++; if ({cy2, ov2, hcy2} !== {m_cy, m_ov, m_hcy}) $display("FAIL rnd_flags @%0d: got %b want %b", n, {cy2, ov2, hcy2}, {m_cy, m_ov, m_hcy}); else passed++;
            total++; if (fl2 !== m_f) $display("FAIL rnd_flag_o @%0d: got %b want %b", n, fl2, m_f); else passed++;
            total++; if (irq2 !== exp_irq(2)) $display("FAIL rnd_irq2 @%0d: got %b want %b", n, irq2, exp_irq(2)); else passed++;
            total++; if (sr3 !== exp_sr(3)) $display("FAIL rnd_sr3 @%0d: got %h want %h", n, sr3, exp_sr(3)); else passed++;
            total++; if (irq3 !== exp_irq(3)) $display("FAIL rnd_irq3 @%0d: got %b want %b", n, irq3, exp_irq(3)); else passed++;
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_flag_capture();
        test_cas_conflict();
        test_ie_priority();
        test_interrupt();
        test_sync_depth();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
